// File: rtl/reg_writeback.sv
// Register-file write-side front end: arbitrates ALU and load results,
// drops writes to r0, queues the rest in order, drains one entry per cycle
// onto the register-file write port, and forwards pending write data.
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_reg,
  input  logic [31:0]            alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [4:0]             mem_reg,
  input  logic [31:0]            mem_data,
  output logic                   mem_ready,
  input  logic [4:0]             lookupReg,
  output logic                   fwdHit,
  output logic [31:0]            fwdData,
  output logic                   regWrite,
  output logic [4:0]             writeReg,
  output logic [31:0]            writeData,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]    r_q_reg  [DEPTH];
  logic [31:0]   r_q_data [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          r_reg_write;
  logic [4:0]    r_write_reg;
  logic [31:0]   r_write_data;

  logic          w_mem_ready;
  logic          w_alu_ready;
  logic          w_enq;
  logic          w_deq;
  logic [4:0]    w_enq_reg;
  logic [31:0]   w_enq_data;
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;

  // Readiness depends only on pre-edge occupancy; a same-cycle pop does not free a slot.
  always_comb begin
    w_mem_ready = rst && (r_count < (PW+1)'(DEPTH));
    w_alu_ready = w_mem_ready && !mem_valid;
  end

  // Select the accepted source (memory has priority) and suppress r0 writes.
  always_comb begin
    w_enq      = 1'b0;
    w_enq_reg  = '0;
    w_enq_data = '0;
    if (mem_valid && w_mem_ready) begin
      w_enq      = (mem_reg != 5'd0);
      w_enq_reg  = mem_reg;
      w_enq_data = mem_data;
    end else if (alu_valid && w_alu_ready) begin
      w_enq      = (alu_reg != 5'd0);
      w_enq_reg  = alu_reg;
      w_enq_data = alu_data;
    end
    w_deq = (r_count != '0);
  end

  // Queue storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_reg[r_wr_ptr]  <= w_enq_reg;
      r_q_data[r_wr_ptr] <= w_enq_data;
    end
  end

  // Pointers and occupancy; wrap is implicit in the PW-bit pointer width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Register-file write port: pop the head every cycle the queue is non-empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_deq) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= r_q_reg[r_rd_ptr];
      r_write_data <= r_q_data[r_rd_ptr];
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  // Forwarding: scan oldest to youngest so later matches override earlier ones,
  // starting from the output register which is older than any queued entry.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (lookupReg != 5'd0) begin
      if (r_reg_write && (r_write_reg == lookupReg)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_write_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = r_rd_ptr + PW'(i);
        if ((i < 32'(r_count)) && (r_q_reg[idx] == lookupReg)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = r_q_data[idx];
        end
      end
    end
  end

  assign mem_ready = w_mem_ready;
  assign alu_ready = w_alu_ready;
  assign fwdHit    = w_fwd_hit;
  assign fwdData   = w_fwd_data;
  assign regWrite  = r_reg_write;
  assign writeReg  = r_write_reg;
  assign writeData = r_write_data;
  assign pending   = r_count;

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_reg, mem_reg, lookupReg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, fwdHit, regWrite;
  logic [31:0] fwdData, writeData;
  logic [4:0]  writeReg;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .lookupReg(lookupReg), .fwdHit(fwdHit), .fwdData(fwdData),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .pending(pending)
  );

  task automatic model_reset();
    mq.delete();
    m_rw = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask

  // Newest pending write to lr: youngest queued entry first, then the output register.
  function automatic void model_fwd(input logic [4:0] lr, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (lr == 5'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].r == lr) begin
        hit = 1'b1;
        d   = mq[i].d;
        return;
      end
    end
    if (m_rw && m_wr == lr) begin
      hit = 1'b1;
      d   = m_wd;
    end
  endfunction

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic tick();
    logic mr, ar, push;
    ent_t e, o;
    mr   = rst && (mq.size() < DEPTH);
    ar   = mr && !mem_valid;
    push = 1'b0;
    e    = '0;
    if (mem_valid && mr) begin
      push = (mem_reg != 5'd0);
      e    = '{r: mem_reg, d: mem_data};
    end else if (alu_valid && ar) begin
      push = (alu_reg != 5'd0);
      e    = '{r: alu_reg, d: alu_data};
    end
    @(posedge clk);
    if (rst) begin
      if (mq.size() > 0) begin
        o    = mq.pop_front();
        m_rw = 1'b1;
        m_wr = o.r;
        m_wd = o.d;
      end else begin
        m_rw = 1'b0;
      end
      if (push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    lookupReg = 5'd0;
    model_reset();
    #1;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite got %b exp 0", regWrite); end
    checks++; if (writeReg !== 5'd0) begin errors++; $display("FAIL reset_writeReg got %0d exp 0", writeReg); end
    checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_writeData got %h exp 0", writeData); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pending); end
    checks++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", mem_ready, alu_ready); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b%b exp 11", mem_ready, alu_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF; lookupReg = 5'd5;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", alu_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending1 got %0d exp 1", pending); end
    checks++; if (fwdHit !== 1'b1 || fwdData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_q got %b %h exp 1 deadbeef", fwdHit, fwdData); end
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", regWrite); end
    tick();
    checks++; if (regWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_commit got %b %0d %h exp 1 5 deadbeef", regWrite, writeReg, writeData); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pending0 got %0d exp 0", pending); end
    checks++; if (fwdHit !== 1'b1 || fwdData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd_out got %b %h exp 1 deadbeef", fwdHit, fwdData); end
    tick();
    checks++; if (regWrite !== 1'b0 || writeReg !== 5'd5 || writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_after got %b %0d %h exp 0 5 deadbeef", regWrite, writeReg, writeData); end
    checks++; if (fwdHit !== 1'b0 || fwdData !== 32'd0) begin errors++; $display("FAIL single_fwd_gone got %b %h exp 0 0", fwdHit, fwdData); end
  endtask

  task automatic test_arbitration();
    mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h22;
    #1;
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL arb_ready got mem %b alu %b exp 1 0", mem_ready, alu_ready); end
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL arb_alu_ready got %b exp 1", alu_ready); end
    tick();
    idle_inputs();
    checks++; if (regWrite !== 1'b1 || writeReg !== 5'd3 || writeData !== 32'h11) begin errors++; $display("FAIL arb_first got %b %0d %h exp 1 3 11", regWrite, writeReg, writeData); end
    tick();
    checks++; if (regWrite !== 1'b1 || writeReg !== 5'd4 || writeData !== 32'h22) begin errors++; $display("FAIL arb_second got %b %0d %h exp 1 4 22", regWrite, writeReg, writeData); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  got_r[$];
    logic [31:0] got_d[$];
    int sent = 0;
    for (int c = 0; c < 12; c++) begin
      if (sent < 6) begin
        alu_valid = 1'b1; alu_reg = 5'(sent + 1); alu_data = 32'(sent + 1);
      end else begin
        idle_inputs();
      end
      #1;
      checks++; if (alu_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL b2b_ready got %b count %0d", alu_ready, mq.size()); end
      if (alu_valid && alu_ready) sent++;
      tick();
      if (regWrite) begin
        got_r.push_back(writeReg);
        got_d.push_back(writeData);
      end
    end
    checks++; if (got_r.size() != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got_r.size()); end
    for (int j = 0; j < got_r.size() && j < 6; j++) begin
      checks++;
      if (got_r[j] !== 5'(j + 1) || got_d[j] !== 32'(j + 1)) begin
        errors++; $display("FAIL b2b_order idx %0d got %0d %h exp %0d", j, got_r[j], got_d[j], j + 1);
      end
    end
  endtask

  task automatic test_reg0();
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFFFFFF; lookupReg = 5'd0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", alu_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL r0_pending got %0d exp 0", pending); end
    checks++; if (fwdHit !== 1'b0) begin errors++; $display("FAIL r0_fwd got %b exp 0", fwdHit); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL r0_regWrite got %b exp 0", regWrite); end
  endtask

  task automatic test_forward_priority();
    lookupReg = 5'd7;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hA;
    tick();
    alu_data = 32'hB;
    #1;
    checks++; if (fwdHit !== 1'b1 || fwdData !== 32'hA) begin errors++; $display("FAIL fwd_first got %b %h exp 1 a", fwdHit, fwdData); end
    tick();
    idle_inputs();
    #1;
    checks++; if (fwdHit !== 1'b1 || fwdData !== 32'hB) begin errors++; $display("FAIL fwd_both got %b %h exp 1 b", fwdHit, fwdData); end
    tick();
    checks++; if (fwdHit !== 1'b1 || fwdData !== 32'hB) begin errors++; $display("FAIL fwd_second got %b %h exp 1 b", fwdHit, fwdData); end
    tick();
    checks++; if (fwdHit !== 1'b0 || fwdData !== 32'd0) begin errors++; $display("FAIL fwd_done got %b %h exp 0 0", fwdHit, fwdData); end
  endtask

  task automatic test_reset_mid();
    lookupReg = 5'd12;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_reg = 5'(10 + k); alu_data = 32'h100 + 32'(k);
      tick();
    end
    alu_reg = 5'd13; alu_data = 32'h103;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (regWrite !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL mid_clear got rw %b pend %0d exp 0 0", regWrite, pending); end
    checks++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b%b exp 00", mem_ready, alu_ready); end
    checks++; if (fwdHit !== 1'b0) begin errors++; $display("FAIL mid_fwd got %b exp 0", fwdHit); end
    tick();
    idle_inputs();
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL mid_stale got %b reg %0d exp 0", regWrite, writeReg); end
    end
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h99;
    tick();
    idle_inputs();
    tick();
    checks++; if (regWrite !== 1'b1 || writeReg !== 5'd9 || writeData !== 32'h99) begin errors++; $display("FAIL mid_new got %b %0d %h exp 1 9 99", regWrite, writeReg, writeData); end
    tick();
  endtask

  task automatic test_random();
    logic        eh;
    logic [31:0] ed;
    for (int c = 0; c < 400; c++) begin
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_reg   = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      alu_valid = ($urandom_range(0, 1) == 0);
      alu_reg   = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      lookupReg = 5'($urandom_range(0, 7));
      #1;
      model_fwd(lookupReg, eh, ed);
      checks++; if (mem_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_mem_ready cyc %0d got %b", c, mem_ready); end
      checks++; if (alu_ready !== ((mq.size() < DEPTH) && !mem_valid)) begin errors++; $display("FAIL rnd_alu_ready cyc %0d got %b", c, alu_ready); end
      checks++; if (fwdHit !== eh || fwdData !== ed) begin errors++; $display("FAIL rnd_fwd cyc %0d reg %0d got %b %h exp %b %h", c, lookupReg, fwdHit, fwdData, eh, ed); end
      checks++; if (pending !== 3'(mq.size())) begin errors++; $display("FAIL rnd_pending cyc %0d got %0d exp %0d", c, pending, mq.size()); end
      tick();
      checks++;
      if (regWrite !== m_rw || (m_rw && (writeReg !== m_wr || writeData !== m_wd))) begin
        errors++; $display("FAIL rnd_commit cyc %0d got %b %0d %h exp %b %0d %h", c, regWrite, writeReg, writeData, m_rw, m_wr, m_wd);
      end
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_back_to_back();
    test_reg0();
    test_forward_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
